// File: rtl/ldpc_pkg.sv
// Shared types and defaults for the LDPC decoder scheduler.
package ldpc_pkg;

    localparam int unsigned ITER_W_DEF = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        VAR,
        SYND,
        DONE
    } ldpc_state_t;

endpackage

// File: rtl/ldpc_sched_if.sv
// Control/status bundle between the LDPC scheduler and its frame controller.
interface ldpc_sched_if
    import ldpc_pkg::*;
#(
    parameter int unsigned ITER_W = ITER_W_DEF
);
    logic              start;
    logic [ITER_W-1:0] max_iter;
    logic              syndrome_ok;
    logic              out_ready;
    logic              busy;
    logic              load_en;
    logic              cn_en;
    logic              vn_en;
    logic [ITER_W-1:0] iter_cnt;
    logic              done;
    logic              converged;

    modport master (
        output start, max_iter, syndrome_ok, out_ready,
        input  busy, load_en, cn_en, vn_en, iter_cnt, done, converged
    );

    modport slave (
        input  start, max_iter, syndrome_ok, out_ready,
        output busy, load_en, cn_en, vn_en, iter_cnt, done, converged
    );
endinterface

// File: rtl/ldpc_phase_timer.sv
// Phase down-counter: reloaded on phase entry, expired while the count is zero.
module ldpc_phase_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);
endmodule

// File: rtl/ldpc_sched.sv
// LDPC layered-decoder phase scheduler (LOAD/CHECK/VAR/SYND iterations).
// Optional early termination on syndrome_ok via macro LDPC_EARLY_TERM_EN.
module ldpc_sched
    import ldpc_pkg::*;
#(
    parameter int unsigned CN_CYCLES = 2,
    parameter int unsigned VN_CYCLES = 1,
    parameter int unsigned ITER_W    = ITER_W_DEF
) (
    input logic         clk,
    input logic         rst,
    ldpc_sched_if.slave bus
);
    localparam int unsigned PH_MAX = (CN_CYCLES > VN_CYCLES) ? CN_CYCLES : VN_CYCLES;
    localparam int unsigned TW     = $clog2(PH_MAX) + 1;

    ldpc_state_t       state, state_nxt;
    logic [ITER_W-1:0] limit;
    logic [ITER_W-1:0] iter_cnt;
    logic [ITER_W:0]   iter_inc;
    logic              last_iter;
    logic              term_early;
    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_expired;
    logic              busy, load_en, cn_en, vn_en, done, converged;

    ldpc_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    assign iter_inc  = {1'b0, iter_cnt} + {{ITER_W{1'b0}}, 1'b1};
    assign last_iter = (iter_inc >= {1'b0, limit});

`ifdef LDPC_EARLY_TERM_EN
    assign term_early = bus.syndrome_ok;
`else
    assign term_early = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            IDLE:  if (bus.start) state_nxt = LOAD;
            LOAD: begin
                state_nxt = CHECK;
                tmr_load  = 1'b1;
                tmr_val   = TW'(CN_CYCLES - 1);
            end
            CHECK: if (tmr_expired) begin
                state_nxt = VAR;
                tmr_load  = 1'b1;
                tmr_val   = TW'(VN_CYCLES - 1);
            end
            VAR:   if (tmr_expired) state_nxt = SYND;
            SYND: begin
                if (term_early || last_iter) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = CHECK;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(CN_CYCLES - 1);
                end
            end
            DONE:  if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are flops loaded from the next-state decode, so they line up
    // with the state register without any combinational path to the ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            limit     <= ITER_W'(1);
            iter_cnt  <= '0;
            busy      <= 1'b0;
            load_en   <= 1'b0;
            cn_en     <= 1'b0;
            vn_en     <= 1'b0;
            done      <= 1'b0;
            converged <= 1'b0;
        end else begin
            state   <= state_nxt;
            busy    <= (state_nxt != IDLE);
            load_en <= (state_nxt == LOAD);
            cn_en   <= (state_nxt == CHECK);
            vn_en   <= (state_nxt == VAR);
            done    <= (state_nxt == DONE);

            if (state == IDLE && bus.start) begin
                limit    <= (bus.max_iter == '0) ? ITER_W'(1) : bus.max_iter;
                iter_cnt <= '0;
            end else if (state == SYND && iter_cnt != '1) begin
                iter_cnt <= iter_cnt + ITER_W'(1);
            end

            // Both exit reasons reduce to the syndrome seen in the final SYND.
            if (state == SYND && state_nxt == DONE) begin
                converged <= bus.syndrome_ok;
            end else if (state_nxt != DONE) begin
                converged <= 1'b0;
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.load_en   = load_en;
    assign bus.cn_en     = cn_en;
    assign bus.vn_en     = vn_en;
    assign bus.iter_cnt  = iter_cnt;
    assign bus.done      = done;
    assign bus.converged = converged;
endmodule

// File: tb/tb_ldpc_sched.sv
// Self-checking bench for ldpc_sched: per-cycle comparison against a schedule model.
module tb_ldpc_sched;
    localparam int unsigned CN = 2;
    localparam int unsigned VN = 1;
    localparam int unsigned IW = 6;
    localparam int unsigned OW = 6 + IW;
`ifdef LDPC_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ldpc_sched_if #(.ITER_W(IW)) bus ();

    ldpc_sched #(.CN_CYCLES(CN), .VN_CYCLES(VN), .ITER_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned checks = 0;
    int unsigned passes = 0;

    bit               syn_it[0:63];
    logic [OW-1:0]    exp_q[$];
    logic [OW-1:0]    msk_q[$];
    bit               syn_q[$];
    bit               st_q[$];
    bit               rdy_q[$];

    function automatic logic [OW-1:0] obs();
        return {bus.busy, bus.load_en, bus.cn_en, bus.vn_en, bus.done, bus.converged, bus.iter_cnt};
    endfunction

    function automatic logic [OW-1:0] mk(bit b, bit l, bit c, bit v, bit d, bit cv, int it);
        return {b, l, c, v, d, cv, IW'(it)};
    endfunction

    task automatic push(input logic [OW-1:0] e, input bit chk_iter, input bit syn, input bit st, input bit rdy);
        exp_q.push_back(e);
        msk_q.push_back(chk_iter ? '1 : {{6{1'b1}}, {IW{1'b0}}});
        syn_q.push_back(syn);
        st_q.push_back(st);
        rdy_q.push_back(rdy);
    endtask

    // Expected outputs for cycles 1.. of a frame started in cycle 0.
    task automatic build(input int lim_in, input int hold, input bit rand_start);
        int lim, n;
        bit conv;
        exp_q.delete(); msk_q.delete(); syn_q.delete(); st_q.delete(); rdy_q.delete();
        lim = (lim_in == 0) ? 1 : lim_in;
        n = lim;
        if (EARLY) begin
            for (int k = lim - 1; k >= 0; k--) if (syn_it[k]) n = k + 1;
        end
        conv = syn_it[n-1];
        push(mk(1, 1, 0, 0, 0, 0, 0), 1, 1'($urandom), rand_start & 1'($urandom), 0);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < int'(CN); c++)
                push(mk(1, 0, 1, 0, 0, 0, k), 1, syn_it[k], rand_start & 1'($urandom), 1'($urandom));
            for (int c = 0; c < int'(VN); c++)
                push(mk(1, 0, 0, 1, 0, 0, k), 1, syn_it[k], rand_start & 1'($urandom), 1'($urandom));
            push(mk(1, 0, 0, 0, 0, 0, k), 1, syn_it[k], rand_start & 1'($urandom), 1'($urandom));
        end
        for (int h = 0; h <= hold; h++)
            push(mk(1, 0, 0, 0, 1, conv, n), 1, 1'($urandom),
                 (h == hold) ? 1'b1 : (rand_start & 1'($urandom)), h == hold);
        push(mk(0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0);
        push(mk(0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int lim);
        bus.start = 1'b1;
        bus.max_iter = IW'(lim);
        tick();
        bus.start = 1'b0;
        bus.max_iter = IW'($urandom);
    endtask

    task automatic test_reset();
        bus.start = 1'b1; bus.max_iter = IW'(5); bus.syndrome_ok = 1'b1; bus.out_ready = 1'b0;
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (obs() !== '0) $display("FAIL reset_state: got %h want %h", obs(), {OW{1'b0}});
        else passes++;
        rst = 1'b0; bus.start = 1'b0;
        tick();
        checks++;
        if (obs() !== '0) $display("FAIL reset_idle: got %h want %h", obs(), {OW{1'b0}});
        else passes++;
    endtask

    // Directed frames: all-converge, never-converge, zero limit, full-limit converge, saturating limit.
    task automatic test_basic();
        int lims[5] = '{5, 3, 0, 4, 63};
        bit syns[5] = '{1, 0, 0, 1, 0};
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 64; k++) syn_it[k] = syns[r];
            build(lims[r], 0, 0);
            kick(lims[r]);
            foreach (exp_q[i]) begin
                bus.syndrome_ok = syn_q[i]; bus.start = st_q[i]; bus.out_ready = rdy_q[i];
                checks++;
                if ((obs() & msk_q[i]) !== (exp_q[i] & msk_q[i]))
                    $display("FAIL basic_lim%0d cyc%0d: got %h want %h", lims[r], i + 1, obs() & msk_q[i], exp_q[i] & msk_q[i]);
                else passes++;
                tick();
            end
        end
    endtask

    task automatic test_done_hold();
        for (int k = 0; k < 64; k++) syn_it[k] = 1'($urandom);
        build(2, 10, 1);
        kick(2);
        foreach (exp_q[i]) begin
            bus.syndrome_ok = syn_q[i]; bus.start = st_q[i]; bus.out_ready = rdy_q[i];
            checks++;
            if ((obs() & msk_q[i]) !== (exp_q[i] & msk_q[i]))
                $display("FAIL done_hold cyc%0d: got %h want %h", i + 1, obs() & msk_q[i], exp_q[i] & msk_q[i]);
            else passes++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 64; k++) syn_it[k] = 1'b0;
        build(4, 0, 0);
        kick(4);
        // cycles 1..5 run normally; cycle 6 is the first cycle of the second CHECK burst
        for (int i = 0; i < 6; i++) begin
            bus.syndrome_ok = syn_q[i]; bus.start = 1'b0; bus.out_ready = 1'b0;
            checks++;
            if ((obs() & msk_q[i]) !== (exp_q[i] & msk_q[i]))
                $display("FAIL pre_reset cyc%0d: got %h want %h", i + 1, obs() & msk_q[i], exp_q[i] & msk_q[i]);
            else passes++;
            if (i < 5) tick();
        end
        rst = 1'b1; bus.start = 1'b1;
        tick();
        rst = 1'b0; bus.start = 1'b0;
        checks++;
        if (obs() !== '0) $display("FAIL mid_reset: got %h want %h", obs(), {OW{1'b0}});
        else passes++;
        tick();
        checks++;
        if (obs() !== '0) $display("FAIL post_reset_idle: got %h want %h", obs(), {OW{1'b0}});
        else passes++;
        for (int k = 0; k < 64; k++) syn_it[k] = 1'($urandom);
        build(3, 1, 0);
        kick(3);
        foreach (exp_q[i]) begin
            bus.syndrome_ok = syn_q[i]; bus.start = st_q[i]; bus.out_ready = rdy_q[i];
            checks++;
            if ((obs() & msk_q[i]) !== (exp_q[i] & msk_q[i]))
                $display("FAIL restart cyc%0d: got %h want %h", i + 1, obs() & msk_q[i], exp_q[i] & msk_q[i]);
            else passes++;
            tick();
        end
    endtask

    task automatic test_random();
        int lim;
        for (int f = 0; f < 15; f++) begin
            lim = int'($urandom_range(0, 6));
            for (int k = 0; k < 64; k++) syn_it[k] = ($urandom_range(0, 3) == 0);
            build(lim, int'($urandom_range(0, 3)), 1);
            kick(lim);
            foreach (exp_q[i]) begin
                bus.syndrome_ok = syn_q[i]; bus.start = st_q[i]; bus.out_ready = rdy_q[i];
                checks++;
                if ((obs() & msk_q[i]) !== (exp_q[i] & msk_q[i]))
                    $display("FAIL random_f%0d cyc%0d: got %h want %h", f, i + 1, obs() & msk_q[i], exp_q[i] & msk_q[i]);
                else passes++;
                tick();
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.max_iter = '0; bus.syndrome_ok = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_done_hold();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
